// File: rtl/img_stream_tx.sv
// img_stream_tx: output image buffer. Random-access fill, then on go a valid/ready stream of every entry from address 0.
// go at edge N -> first beat valid after N+2; a 2-entry skid absorbs backpressure. `STREAM_CKSUM_EN appends a sum beat.
`ifndef WD
`define WD 15
`endif

module img_stream_tx #(
  parameter int DEPTH = 784,
  parameter int AW    = 12,
  parameter int DW    = `WD + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cenw,
  input  logic [AW-1:0] aw,
  input  logic [DW-1:0] dw,
  input  logic          go,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          wr_drop
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] rd_dat;
  logic          rd_vld, rd_last, rd_last_nxt;
  logic [DW-1:0] sk0_dat, sk1_dat;
  logic          sk0_last, sk1_last;
  logic [1:0]    sk_cnt;
  logic          pop, push, rd_en, go_acc, fin, wr_ok;
  logic [DW-1:0] push_dat;
  logic          push_last;
  logic [2:0]    occ;

  assign busy      = (state != IDLE);
  assign out_valid = (sk_cnt != 2'd0);
  assign out_data  = sk0_dat;
  assign out_last  = out_valid && sk0_last;

  // occ counts skid entries plus the read in flight, as they will stand after this edge's pop
  always_comb begin
    pop       = out_valid && out_ready;
    fin       = pop && out_last && (state == DRAIN);
    go_acc    = go && ((state == IDLE) || fin);
    occ       = 3'(sk_cnt) + 3'(rd_vld) - 3'(pop);
    rd_en     = (state == STREAM) && (occ <= 3'd1);
    wr_ok     = !cenw && !busy && (aw < DEPTH_A);
    state_nxt = state;
    case (state)
      IDLE:    if (go_acc) state_nxt = STREAM;
      STREAM:  if (rd_en && (rd_ptr == LAST_A)) state_nxt = DRAIN;
      DRAIN:   if (fin) state_nxt = go_acc ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[aw[IW-1:0]] <= dw;
    if (rd_en) rd_dat <= mem[rd_ptr[IW-1:0]];
  end

`ifdef STREAM_CKSUM_EN
  logic [DW-1:0] sum;
  logic          cks_sent;
  logic          cks_push;

  // the sum beat is injected once every data beat has left the skid
  assign cks_push    = (state == DRAIN) && !cks_sent && !rd_vld && (sk_cnt == 2'd0);
  assign rd_last_nxt = 1'b0;
  assign push        = rd_vld || cks_push;
  assign push_dat    = rd_vld ? rd_dat : sum;
  assign push_last   = rd_vld ? rd_last : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum      <= '0;
      cks_sent <= 1'b0;
    end else if (go_acc) begin
      sum      <= '0;
      cks_sent <= 1'b0;
    end else begin
      if (pop && !out_last) sum <= sum + out_data;
      if (cks_push) cks_sent <= 1'b1;
    end
  end
`else
  assign rd_last_nxt = (rd_ptr == LAST_A);
  assign push        = rd_vld;
  assign push_dat    = rd_dat;
  assign push_last   = rd_last;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      rd_vld  <= rd_en;
      done    <= fin;
      wr_drop <= !cenw && !wr_ok;
      if (rd_en) rd_last <= rd_last_nxt;
      if (go_acc)
        rd_ptr <= '0;
      else if (rd_en && (rd_ptr != LAST_A))
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // skid: sk0 is the presented beat, sk1 holds the beat that arrives during a stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sk_cnt   <= 2'd0;
      sk0_dat  <= '0;
      sk0_last <= 1'b0;
      sk1_dat  <= '0;
      sk1_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            sk0_dat  <= push_dat;
            sk0_last <= push_last;
          end else begin
            sk1_dat  <= push_dat;
            sk1_last <= push_last;
          end
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk0_dat  <= sk1_dat;
          sk0_last <= sk1_last;
          sk_cnt   <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            sk0_dat  <= push_dat;
            sk0_last <= push_last;
          end else begin
            sk0_dat  <= sk1_dat;
            sk0_last <= sk1_last;
            sk1_dat  <= push_dat;
            sk1_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
